// File: rtl/wb_arbiter_pkg.sv
// Shared register-file write types: address pointer width, pending-buffer depth and entry layout.
package wb_arbiter_pkg;

  localparam int unsigned pw    = 3;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [pw-1:0] addr;
    logic [7:0]    dat;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-load buffer: in-order FIFO with head pop, tail push and address-match invalidate.
// Surviving entries are compacted toward the head in the same cycle.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned Depth = DEPTH,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push_i,
  input  wb_entry_t       push_entry_i,
  input  logic            pop_i,
  input  logic            kill_i,
  input  logic [pw-1:0]   kill_addr_i,
  output wb_entry_t       head_o,
  output logic [CntW-1:0] cnt_o
);

  wb_entry_t       ent_q [Depth];
  wb_entry_t       ent_d [Depth];
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    logic [CntW-1:0] n;
    ent_d = ent_q;
    n     = '0;
    // Pop and kill are applied first; survivors are packed from slot 0 in age order.
    for (int i = 0; i < Depth; i++) begin
      if ((CntW'(i) < cnt_q) && !(pop_i && (i == 0)) &&
          !(kill_i && (ent_q[i].addr == kill_addr_i))) begin
        ent_d[n[IdxW-1:0]] = ent_q[i];
        n = n + CntW'(1);
      end
    end
    if (push_i && (n < CntW'(Depth))) begin
      ent_d[n[IdxW-1:0]] = push_entry_i;
      n = n + CntW'(1);
    end
    cnt_d = n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      for (int i = 0; i < Depth; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < Depth; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign head_o = ent_q[0];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results win, buffered loads drain in order,
// and an ALU write kills any older pending load to the same register.
module wb_arbiter
  import wb_arbiter_pkg::wb_entry_t;
#(
  parameter int unsigned pw    = wb_arbiter_pkg::pw,
  parameter int unsigned DEPTH = wb_arbiter_pkg::DEPTH,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_vld,
  input  logic [pw-1:0]   alu_addr,
  input  logic [7:0]      alu_dat,
  input  logic            mem_vld,
  input  logic [pw-1:0]   mem_addr,
  input  logic [7:0]      mem_dat,
  output logic            mem_rdy,
  output logic            wr_en,
  output logic [pw-1:0]   wr_addr,
  output logic [7:0]      wr_dat,
  output logic [CntW-1:0] pend_cnt
);

  logic            wr_en_q, wr_en_d;
  logic [pw-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_dat_q, wr_dat_d;
  logic            push, pop, mem_xfer;
  wb_entry_t       head, mem_ent;

  assign mem_rdy  = (pend_cnt < CntW'(DEPTH));
  assign mem_xfer = mem_vld & mem_rdy;
  assign mem_ent  = '{addr: mem_addr, dat: mem_dat};

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_dat_d  = wr_dat_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (alu_vld) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_addr;
      wr_dat_d  = alu_dat;
      // A same-cycle load to the ALU's register is already stale.
      push      = mem_xfer && (mem_addr != alu_addr);
    end else if (pend_cnt != '0) begin
      wr_en_d   = 1'b1;
      wr_addr_d = head.addr;
      wr_dat_d  = head.dat;
      pop       = 1'b1;
      push      = mem_xfer;
    end else if (mem_xfer) begin
      wr_en_d   = 1'b1;
      wr_addr_d = mem_addr;
      wr_dat_d  = mem_dat;
    end
  end

  wb_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (push),
    .push_entry_i (mem_ent),
    .pop_i        (pop),
    .kill_i       (alu_vld),
    .kill_addr_i  (alu_addr),
    .head_o       (head),
    .cnt_o        (pend_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_dat_q  <= wr_dat_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_dat  = wr_dat_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then random traffic, all checked against a
// queue-based model of the write-port rules.
module tb_wb_arbiter;

  localparam int unsigned Depth = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       alu_vld = 1'b0;
  logic [2:0] alu_addr = '0;
  logic [7:0] alu_dat = '0;
  logic       mem_vld = 1'b0;
  logic [2:0] mem_addr = '0;
  logic [7:0] mem_dat = '0;
  logic       mem_rdy;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_dat;
  logic [1:0] pend_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } model_ent_t;

  model_ent_t mq[$];
  logic       exp_en   = 1'b0;
  logic [2:0] exp_addr = '0;
  logic [7:0] exp_dat  = '0;

  wb_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .alu_vld  (alu_vld),
    .alu_addr (alu_addr),
    .alu_dat  (alu_dat),
    .mem_vld  (mem_vld),
    .mem_addr (mem_addr),
    .mem_dat  (mem_dat),
    .mem_rdy  (mem_rdy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_dat   (wr_dat),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict from the queue model, then compare after the edge.
  task automatic step(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                      input logic mv, input logic [2:0] ma, input logic [7:0] md);
    logic       xfer;
    model_ent_t e;
    model_ent_t keep[$];
    alu_vld = av; alu_addr = aa; alu_dat = ad;
    mem_vld = mv; mem_addr = ma; mem_dat = md;
    #1;
    check("mem_rdy", 32'(mem_rdy), 32'(mq.size() < Depth));
    xfer   = mv && (mq.size() < Depth);
    exp_en = 1'b0;
    if (av) begin
      exp_en = 1'b1; exp_addr = aa; exp_dat = ad;
      foreach (mq[i]) if (mq[i].a != aa) keep.push_back(mq[i]);
      mq = keep;
      if (xfer && (ma != aa)) mq.push_back('{a: ma, d: md});
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_en = 1'b1; exp_addr = e.a; exp_dat = e.d;
      if (xfer) mq.push_back('{a: ma, d: md});
    end else if (xfer) begin
      exp_en = 1'b1; exp_addr = ma; exp_dat = md;
    end
    @(posedge clk);
    #1;
    check("wr_en", 32'(wr_en), 32'(exp_en));
    check("wr_addr", 32'(wr_addr), 32'(exp_addr));
    check("wr_dat", 32'(wr_dat), 32'(exp_dat));
    check("pend_cnt", 32'(pend_cnt), 32'(mq.size()));
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
  endtask

  // Asynchronous pulse between edges; outputs must clear before any clock arrives.
  task automatic pulse_reset();
    alu_vld = 1'b0; mem_vld = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_dat", 32'(wr_dat), 32'd0);
    check("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    check("rst_mem_rdy", 32'(mem_rdy), 32'd1);
    #1;
    reset_n = 1'b1;
    mq.delete();
    exp_en = 1'b0; exp_addr = '0; exp_dat = '0;
  endtask

  initial begin
    #2;
    pulse_reset();
    @(posedge clk);
    #1;

    // Single ALU write, then idle.
    step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
    check("r29_en", 32'(wr_en), 32'd1);
    check("r29_addr", 32'(wr_addr), 32'd3);
    check("r29_dat", 32'(wr_dat), 32'h5A);
    idle();
    check("r29_off", 32'(wr_en), 32'd0);

    // ALU and load in the same cycle: load lands one cycle later.
    step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    check("r30_pend", 32'(pend_cnt), 32'd1);
    idle();
    check("r30_second", 32'({wr_en, wr_addr, wr_dat}), 32'({1'b1, 3'd2, 8'h22}));

    // Buffer fills under continuous ALU traffic, then drains in order.
    step(1'b1, 3'd1, 8'h01, 1'b1, 3'd4, 8'hA0);
    step(1'b1, 3'd1, 8'h02, 1'b1, 3'd5, 8'hB0);
    step(1'b1, 3'd1, 8'h03, 1'b1, 3'd6, 8'hC0);
    check("r31_full", 32'(pend_cnt), 32'd2);
    step(1'b1, 3'd1, 8'h04, 1'b1, 3'd6, 8'hC0);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'hC0);
    check("r31_w4", 32'(wr_dat), 32'hA0);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'hC0);
    check("r31_w5", 32'(wr_dat), 32'hB0);
    idle();
    check("r31_w6", 32'(wr_dat), 32'hC0);
    idle();

    // Write-after-write kill of a pending load.
    step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    step(1'b1, 3'd2, 8'h99, 1'b0, 3'd0, 8'h00);
    check("r32_dat", 32'(wr_dat), 32'h99);
    check("r32_pend", 32'(pend_cnt), 32'd0);
    idle();
    check("r32_noissue", 32'(wr_en), 32'd0);

    // Reset with two loads pending.
    step(1'b1, 3'd1, 8'h10, 1'b1, 3'd3, 8'h33);
    step(1'b1, 3'd1, 8'h20, 1'b1, 3'd4, 8'h44);
    check("r33_two", 32'(pend_cnt), 32'd2);
    pulse_reset();
    idle();
    check("r33_nostale", 32'(wr_en), 32'd0);
    idle();

    // Random traffic on a narrow address range to provoke kills and full-buffer stalls.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) pulse_reset();
      step(1'($urandom_range(0, 99) < 45), 3'($urandom_range(0, 3)), 8'($urandom),
           1'($urandom_range(0, 99) < 60), 3'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL take parameter pw, default 3, as the register address pointer width (2**pw registers).
REQ-002 The block SHALL take parameter DEPTH, default 2, as the number of entries in the pending-load buffer.
REQ-003 Port clk  input  1  single clock; all state updates on posedge.
REQ-004 Port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port alu_vld  input  1  ALU result valid this cycle; always accepted, no backpressure.
REQ-006 Port alu_addr  input  pw  ALU destination register.
REQ-007 Port alu_dat  input  8  ALU result data.
REQ-008 Port mem_vld  input  1  load data valid this cycle.
REQ-009 Port mem_addr  input  pw  load destination register.
REQ-010 Port mem_dat  input  8  load data.
REQ-011 Port mem_rdy  output  1  buffer can accept load data; a beat transfers only when mem_vld and mem_rdy are both high.
REQ-012 Port wr_en  output  1  register-file write enable, registered.
REQ-013 Port wr_addr  output  pw  register-file write address, registered.
REQ-014 Port wr_dat  output  8  register-file write data, registered.
REQ-015 Port pend_cnt  output  $clog2(DEPTH+1)  number of valid pending-buffer entries.

Function
REQ-016 mem_rdy SHALL equal (pend_cnt < DEPTH), combinationally from current state only; it SHALL NOT depend on alu_vld.
REQ-017 Each cycle, the write source for the next registered write SHALL be selected in this priority: the ALU if alu_vld; else the buffer head if the buffer is non-empty; else the mem beat if it transfers; else none.
REQ-018 Latency SHALL be exactly one cycle: the selected source appears on wr_en/wr_addr/wr_dat at the next posedge; when no source is selected, wr_en=0 and wr_addr/wr_dat hold their previous values.
REQ-019 A transferred mem beat not selected in the same cycle SHALL be pushed at the buffer tail; if the buffer head is popped in the same cycle, the push and pop SHALL both occur and pend_cnt SHALL stay unchanged.
REQ-020 Buffer order SHALL be FIFO; a transferred beat SHALL never be lost or duplicated.
REQ-021 WAW kill: when alu_vld is high, every valid buffer entry whose address equals alu_addr SHALL be invalidated at that posedge, and a same-cycle mem beat to alu_addr SHALL be discarded rather than pushed; pend_cnt SHALL drop accordingly.
REQ-022 Invalidated entries SHALL be compacted out, so the head is always the oldest surviving entry, with no bubble cycle.
REQ-023 When DEPTH entries are pending and alu_vld is held high, the buffer SHALL stall (no pop), mem_rdy SHALL stay 0, and ALU writes SHALL continue every cycle.
REQ-024 wr_en SHALL NOT assert in two different sources' favour in one cycle; at most one register write occurs per cycle.

Reset
REQ-025 Asserting reset_n low SHALL immediately clear the buffer (pend_cnt=0), set wr_en=0, wr_addr=0, wr_dat=0, and drive mem_rdy=1.
REQ-026 Reset asserted mid-operation SHALL discard all pending entries without issuing their writes; the first write after release SHALL come only from inputs sampled after release.

Structure
REQ-027 A shared package SHALL hold pw, DEPTH, and typedef wb_entry_t {addr[pw-1:0], dat[7:0]}, which the register file and this block also use.
REQ-028 The pending buffer with push/pop/address-match invalidate SHALL be a sub-module wb_fifo; selection and output registers SHALL stay in wb_arbiter.

Verification
REQ-029 Idle then alu_vld=1, alu_addr=3, alu_dat=0x5A for one cycle -> next cycle wr_en=1, wr_addr=3, wr_dat=0x5A; the cycle after that wr_en=0.
REQ-030 Same cycle alu_vld (r1,0x11) and mem_vld (r2,0x22) -> cycle+1 writes r1=0x11, cycle+2 writes r2=0x22, and pend_cnt is 1 between those writes.
REQ-031 alu_vld held high 4 cycles while mem beats r4=0xA0, r5=0xB0, r6=0xC0 are offered -> first two accepted, mem_rdy=0 with the third held, pend_cnt=2; after alu_vld drops, writes r4, r5, r6 in order, one per cycle.
REQ-032 Pending r2=0x22, then alu_vld r2=0x99 -> only 0x99 is written to r2, the pending entry never issues, and pend_cnt returns to 0.
REQ-033 Two entries pending, reset_n pulsed low asynchronously between edges -> wr_en=0, pend_cnt=0, and mem_rdy=1 immediately; no stale writes after release.
